// File: rtl/inv_rr_arbiter.sv
// inv_rr_arbiter: round-robin sharing of one external inverter lane between NUM_REQ requesters
module inv_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [WIDTH-1:0]           inv_a,
    input  logic [WIDTH-1:0]           inv_y,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    state_t                          state;
    logic [IW-1:0]                   ptr, cur_id, win, nxt_id, j;
    logic [CW-1:0]                   cnt;
    logic [NUM_REQ-1:0][WIDTH-1:0]   ops;

    assign ops    = req_data;
    assign nxt_id = cur_id == IW'(NUM_REQ - 1) ? '0 : cur_id + IW'(1);

    // Scan from farthest to nearest offset so the closest request at/after ptr wins
    always_comb begin
        win = ptr;
        j   = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[j]) win = j;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_id    <= '0;
            cnt       <= '0;
            inv_a     <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    cur_id <= win;
                    inv_a  <= ops[win];
                    cnt    <= CW'(HOLD_CYC - 1);
                    busy   <= 1'b1;
                    state  <= HOLD;
                end
                // A withdrawn request aborts even on the final hold cycle
                HOLD: if (!req[cur_id]) begin
                    ptr   <= nxt_id;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (cnt == '0) begin
                    rsp_data  <= inv_y;
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    gnt       <= NUM_REQ'(1) << cur_id;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: begin
                    rsp_valid <= 1'b0;
                    gnt       <= '0;
                    busy      <= 1'b0;
                    ptr       <= nxt_id;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inv_rr_arbiter.sv
// tb_inv_rr_arbiter: directed scenarios plus a randomized run against a cycle-schedule model
module tb_inv_rr_arbiter;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  inv_a, inv_y, rsp_data;
    logic [3:0]  gnt;
    logic        rsp_valid, busy;
    logic [1:0]  rsp_id;

    logic [3:0]  req2;
    logic [63:0] req_data2;
    logic [15:0] inv_a2, inv_y2, rsp_data2;
    logic [3:0]  gnt2;
    logic        rsp_valid2, busy2;
    logic [1:0]  rsp_id2;

    int checks = 0;
    int passed = 0;

    int         pc[$];
    logic [1:0] pid[$];
    logic [7:0] pd[$];
    logic [3:0] pg[$];
    logic [7:0] first_a;

    assign inv_y  = ~inv_a;
    assign inv_y2 = ~inv_a2;

    always #5 clk = ~clk;

    inv_rr_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .inv_a(inv_a), .inv_y(inv_y),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    inv_rr_arbiter #(.NUM_REQ(4), .WIDTH(16), .HOLD_CYC(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_data(req_data2), .inv_a(inv_a2), .inv_y(inv_y2),
        .gnt(gnt2), .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_data(rsp_data2), .busy(busy2)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Records every response pulse; optionally drops a request once its gnt is seen
    task automatic watch(input int ncyc, input bit drop);
        pc.delete(); pid.delete(); pd.delete(); pg.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) first_a = inv_a;
            if (rsp_valid === 1'b1) begin
                pc.push_back(c); pid.push_back(rsp_id); pd.push_back(rsp_data); pg.push_back(gnt);
                if (drop) req = req & ~gnt;
            end
        end
    endtask

    task automatic test_reset();
        req = '0; req_data = '0; req2 = '0; req_data2 = '0;
        rst_n = 1'b0;
        #12;
        checks++; if ({inv_a, gnt, rsp_valid, rsp_id, rsp_data, busy} !== '0)
            $display("FAIL reset_outputs: got %h want 0", {inv_a, gnt, rsp_valid, rsp_id, rsp_data, busy}); else passed++;
        checks++; if ({inv_a2, gnt2, rsp_valid2, rsp_id2, rsp_data2, busy2} !== '0)
            $display("FAIL reset_outputs2: got %h want 0", {inv_a2, gnt2, rsp_valid2, rsp_id2, rsp_data2, busy2}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL reset_idle: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); else passed++;
    endtask

    task automatic test_single();
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        watch(6, 1'b1);
        checks++; if (first_a !== 8'hA5) $display("FAIL single_inv_a: got %h want a5", first_a); else passed++;
        checks++; if (pc.size() !== 1) $display("FAIL single_count: got %0d want 1", pc.size()); else passed++;
        checks++; if (pc[0] !== HOLD + 1) $display("FAIL single_latency: got %0d want %0d", pc[0], HOLD + 1); else passed++;
        checks++; if (pg[0] !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", pg[0]); else passed++;
        checks++; if (pid[0] !== 2'd0) $display("FAIL single_id: got %0d want 0", pid[0]); else passed++;
        checks++; if (pd[0] !== 8'h5A) $display("FAIL single_data: got %h want 5a", pd[0]); else passed++;
        checks++; if (rsp_data !== 8'h5A || gnt !== 4'b0 || busy !== 1'b0)
            $display("FAIL single_after: rsp_data=%h gnt=%b busy=%b want 5a 0000 0", rsp_data, gnt, busy); else passed++;
    endtask

    task automatic test_all_ones();
        logic [7:0] exp_d [5] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'hFF};
        do_reset();
        req_data = {8'hF0, 8'h0F, 8'hFF, 8'h00};
        req = 4'b1111;
        watch(19, 1'b0);
        req = '0;
        checks++; if (pc.size() !== 5) $display("FAIL rr_count: got %0d want 5", pc.size()); else passed++;
        for (int k = 0; k < 5; k++) begin
            checks++; if (pid[k] !== 2'(k) || pg[k] !== 4'(1 << (k % 4)))
                $display("FAIL rr_order[%0d]: got id %0d gnt %b want id %0d", k, pid[k], pg[k], k % 4); else passed++;
            checks++; if (pd[k] !== exp_d[k]) $display("FAIL rr_data[%0d]: got %h want %h", k, pd[k], exp_d[k]); else passed++;
            checks++; if (pc[k] !== 3 + 4 * k) $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, pc[k], 3 + 4 * k); else passed++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pointer();
        do_reset();
        req_data = {8'h3C, 8'h00, 8'h96, 8'h00};
        req = 4'b1000;
        watch(6, 1'b1);
        checks++; if (pc.size() !== 1 || pid[0] !== 2'd3) $display("FAIL ptr_first: got n=%0d id %0d want 1 id 3", pc.size(), pid[0]); else passed++;
        req = 4'b1010;
        watch(10, 1'b1);
        checks++; if (pc.size() !== 2) $display("FAIL ptr_count: got %0d want 2", pc.size()); else passed++;
        checks++; if (pid[0] !== 2'd1 || pd[0] !== 8'h69) $display("FAIL ptr_wrap0: got id %0d data %h want 1 69", pid[0], pd[0]); else passed++;
        checks++; if (pid[1] !== 2'd3 || pd[1] !== 8'hC3) $display("FAIL ptr_wrap1: got id %0d data %h want 3 c3", pid[1], pd[1]); else passed++;
    endtask

    task automatic test_abort();
        req_data = {8'h00, 8'h5E, 8'h00, 8'h00};
        req = 4'b0100;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || inv_a !== 8'h5E) $display("FAIL abort_grant: busy=%b inv_a=%h want 1 5e", busy, inv_a); else passed++;
        req = 4'b0000;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || gnt !== 4'b0)
            $display("FAIL abort_idle: busy=%b rsp_valid=%b gnt=%b want 0 0 0000", busy, rsp_valid, gnt); else passed++;
        watch(5, 1'b1);
        checks++; if (pc.size() !== 0) $display("FAIL abort_no_rsp: got %0d pulses want 0", pc.size()); else passed++;
        req_data = {8'h00, 8'h22, 8'h00, 8'h11};
        req = 4'b0101;
        watch(10, 1'b1);
        checks++; if (pc.size() !== 2) $display("FAIL abort_next_count: got %0d want 2", pc.size()); else passed++;
        checks++; if (pid[0] !== 2'd0 || pd[0] !== 8'hEE) $display("FAIL abort_next0: got id %0d data %h want 0 ee", pid[0], pd[0]); else passed++;
        checks++; if (pid[1] !== 2'd2 || pd[1] !== 8'hDD) $display("FAIL abort_next1: got id %0d data %h want 2 dd", pid[1], pd[1]); else passed++;
    endtask

    task automatic test_reset_mid();
        req_data = {8'h00, 8'h77, 8'h00, 8'h00};
        req = 4'b0100;
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", busy); else passed++;
        #2 rst_n = 1'b0;
        req = '0;
        #1;
        checks++; if ({inv_a, gnt, rsp_valid, rsp_id, rsp_data, busy} !== '0)
            $display("FAIL rstmid_async: got %h want 0", {inv_a, gnt, rsp_valid, rsp_id, rsp_data, busy}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        watch(6, 1'b1);
        checks++; if (pc.size() !== 0) $display("FAIL rstmid_lost: got %0d pulses want 0", pc.size()); else passed++;
        req_data = {8'h00, 8'h81, 8'h00, 8'h00};
        req = 4'b0100;
        watch(6, 1'b1);
        checks++; if (pc.size() !== 1 || pc[0] !== HOLD + 1) $display("FAIL rstmid_retry: got n=%0d at %0d want 1 at %0d", pc.size(), pc[0], HOLD + 1); else passed++;
        checks++; if (pid[0] !== 2'd2 || pd[0] !== 8'h7E) $display("FAIL rstmid_rsp: got id %0d data %h want 2 7e", pid[0], pd[0]); else passed++;
    endtask

    task automatic test_hold1();
        int n, at;
        logic [15:0] d, a1;
        logic [3:0]  g;
        n = 0; at = 0; d = '0; a1 = '0; g = '0;
        req_data2[15:0] = 16'h1234;
        req2 = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) a1 = inv_a2;
            if (rsp_valid2 === 1'b1) begin
                n++; at = c; d = rsp_data2; g = gnt2;
                req2 = req2 & ~gnt2;
            end
        end
        checks++; if (a1 !== 16'h1234) $display("FAIL hold1_inv_a: got %h want 1234", a1); else passed++;
        checks++; if (n !== 1 || at !== 2) $display("FAIL hold1_latency: got n=%0d at %0d want 1 at 2", n, at); else passed++;
        checks++; if (d !== 16'hEDCB || g !== 4'b0001) $display("FAIL hold1_rsp: got %h gnt %b want edcb 0001", d, g); else passed++;
    endtask

    // Model: a request accepted at edge c responds after edge c+HOLD; the arbiter samples again at c+HOLD+2
    task automatic test_random();
        int cyc, acc, due, free_at, p, id, just;
        logic [7:0] op;
        bit found;
        do_reset();
        cyc = 0; acc = -100; due = -100; free_at = 0; p = 0; id = 0; just = -1; op = '0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) begin
                    req_data[i*8 +: 8] = 8'($urandom);
                    if (i != just && $urandom_range(3) == 0) req[i] = 1'b1;
                end
            end
            just = -1;
            @(posedge clk);
            cyc++;
            if (cyc >= free_at && req != 4'b0) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[2'(p + k)]) begin
                        id = (p + k) % 4;
                        found = 1'b1;
                    end
                end
                op = req_data[id*8 +: 8];
                acc = cyc; due = cyc + HOLD; free_at = cyc + HOLD + 2; p = (id + 1) % 4;
            end
            @(negedge clk);
            checks++; if (rsp_valid !== (cyc == due)) $display("FAIL rnd_valid@%0d: got %b want %b", cyc, rsp_valid, cyc == due); else passed++;
            checks++; if (busy !== (cyc >= acc && cyc <= due)) $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, cyc >= acc && cyc <= due); else passed++;
            if (cyc >= acc && cyc <= due) begin
                checks++; if (inv_a !== op) $display("FAIL rnd_inv_a@%0d: got %h want %h", cyc, inv_a, op); else passed++;
            end
            if (cyc == due) begin
                checks++; if (gnt !== 4'(1 << id) || rsp_id !== 2'(id))
                    $display("FAIL rnd_gnt@%0d: got gnt %b id %0d want id %0d", cyc, gnt, rsp_id, id); else passed++;
                checks++; if (rsp_data !== ~op) $display("FAIL rnd_data@%0d: got %h want %h", cyc, rsp_data, ~op); else passed++;
                req[id] = 1'b0;
                just = id;
            end
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_ones();
        test_pointer();
        test_abort();
        test_reset_mid();
        test_hold1();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
